// File: rtl/mem_pkg.sv
// mem_pkg: types and defaults shared by the memory arbiter files.
//   mem_cmd_t   : the command a port presents (MNONE, MWRITE, MREAD; 2'b11 acts as MNONE)
//   arb_state_t : the arbiter sequencer states
//   DATA_W_DEF / ADDR_W_DEF : default data and port address widths
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MWRITE = 2'b01,
    MREAD  = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RDATA  = 2'b10
  } arb_state_t;

  // 2'b11 is not a legal command and must never start an access.
  function automatic logic cmd_is_pending(input logic [1:0] cmd);
    return (cmd == MWRITE) || (cmd == MREAD);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between the two ports.
// Optional feature macro: MEM_ARB_RR_EN (round-robin when defined,
// fixed priority with port 0 first when undefined).
// Ports:
//   pend0_i, pend1_i : port has a MREAD/MWRITE pending
//   last_i           : port that won the previous grant (MEM_ARB_RR_EN only)
//   valid_o          : some port is pending
//   port_o           : winning port id (0 or 1)
module mem_arb_pick (
  input  logic pend0_i,
  input  logic pend1_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_i,
`endif
  output logic valid_o,
  output logic port_o
);

  always_comb begin
    valid_o = pend0_i | pend1_i;
    port_o  = 1'b0;
    if (pend0_i && pend1_i) begin
`ifdef MEM_ARB_RR_EN
      port_o = ~last_i;
`else
      port_o = 1'b0;
`endif
    end else if (pend1_i) begin
      port_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256x16 synchronous-read RAM between port 0 (CPU)
// and port 1 (loader/debug). One access at a time: IDLE samples the ports,
// ACCESS drives the RAM, RDATA returns registered RAM data for in-range reads.
// Addresses with the top bit set never touch the RAM and read as zero.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration.
//
// state  | meaning
// IDLE   | sample both ports, latch the winner's request
// ACCESS | drive RAM address/write; ack writes and out-of-range accesses
// RDATA  | RAM output valid; ack the read with ram_dout
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   mem_cmd0/1, mem_addr0/1         : per-port command and address
//   write_data0/1                   : per-port write data
//   ack0, ack1                      : one-cycle completion pulse per port
//   read_data                       : read result, zero unless a read is acked
//   ram_addr, ram_write, ram_din    : RAM address, write enable, write data
//   ram_dout                        : registered RAM read data
//   busy                            : high whenever not IDLE
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RAM_AW = ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd0,
  input  logic [1:0]        mem_cmd1,
  input  logic [ADDR_W-1:0] mem_addr0,
  input  logic [ADDR_W-1:0] mem_addr1,
  input  logic [DATA_W-1:0] write_data0,
  input  logic [DATA_W-1:0] write_data1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] read_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              port_q;
  logic              is_read_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic pend0, pend1, grant_valid, grant_port, capture;
  logic out_of_range, ack_any;
  logic [1:0] sel_cmd;

  assign pend0 = cmd_is_pending(mem_cmd0);
  assign pend1 = cmd_is_pending(mem_cmd1);

`ifdef MEM_ARB_RR_EN
  logic last_q;
`endif

  mem_arb_pick u_pick (
    .pend0_i (pend0),
    .pend1_i (pend1),
`ifdef MEM_ARB_RR_EN
    .last_i  (last_q),
`endif
    .valid_o (grant_valid),
    .port_o  (grant_port)
  );

  assign capture = (state_q == IDLE) && grant_valid;
  assign sel_cmd = grant_port ? mem_cmd1 : mem_cmd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        port_q    <= grant_port;
        is_read_q <= (sel_cmd == MREAD);
        addr_q    <= grant_port ? mem_addr1 : mem_addr0;
        wdata_q   <= grant_port ? write_data1 : write_data0;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset to port 1 so that port 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (capture) begin
      last_q <= grant_port;
    end
  end
`endif

  assign out_of_range = addr_q[ADDR_W-1];
  assign ram_addr     = addr_q[RAM_AW-1:0];
  assign ram_din      = wdata_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    ack_any   = 1'b0;
    ram_write = 1'b0;
    read_data = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ACCESS;
      end
      ACCESS: begin
        if (!is_read_q) begin
          ram_write = ~out_of_range;
          ack_any   = 1'b1;
          state_d   = IDLE;
        end else if (out_of_range) begin
          ack_any = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        ack_any   = 1'b1;
        read_data = ram_dout;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle abandons the transaction: no ack and no RAM write.
    if (reset) begin
      ack_any   = 1'b0;
      ram_write = 1'b0;
      read_data = '0;
    end
  end

  assign ack0 = ack_any & ~port_q;
  assign ack1 = ack_any & port_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single synchronous-read RAM (256 × 16, one-cycle read latency) between two requesters: port 0, the CPU memory interface, and port 1, a loader/debug port. Each port issues MREAD/MWRITE/MNONE commands with a 9-bit address. The arbiter grants one access at a time, drives the RAM address, write strobe and write data, and returns read data with a per-port acknowledge. Addresses with bit 8 set are outside RAM: they are acknowledged without touching memory, and reads of them return zero.

## Interface
Parameters:
- DATA_W, 16, data width of the RAM and of both ports
- ADDR_W, 9, port address width; bit ADDR_W-1 is the RAM select (0 selects RAM)
- RAM_AW, 8, RAM address width (ADDR_W-1)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- mem_cmd0, mem_cmd1  in  2  command per port: MNONE=00, MWRITE=01, MREAD=10; 11 is treated as MNONE
- mem_addr0, mem_addr1  in  ADDR_W  address per port
- write_data0, write_data1  in  DATA_W  write data per port
- ack0, ack1  out  1  one-cycle completion pulse per port
- read_data  out  DATA_W  read result; valid only while ack0 or ack1 is high for a read
- ram_addr  out  RAM_AW  RAM read and write address
- ram_write  out  1  RAM write enable
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  registered RAM output
- busy  out  1  high in every state other than IDLE

## Operation
- A port is pending when its cmd is MREAD or MWRITE. The port must hold cmd, addr and wdata stable until it sees its ack.
- State machine IDLE → ACCESS → (RDATA) → IDLE:
  - IDLE: if any port is pending, pick a winner and latch its port id, cmd, addr and wdata. Move to ACCESS. If nothing is pending, stay in IDLE.
  - ACCESS: ram_addr = latched addr[7:0].
    - Write to RAM (addr[8]=0): ram_write=1 and ram_din = latched wdata for exactly this cycle.
    - Write, or any access with addr[8]=1: assert ack of the winning port and go to IDLE. For an addr[8]=1 read, read_data = 0.
    - Read with addr[8]=0: go to RDATA; no ack.
  - RDATA: assert ack of the winning port with read_data = ram_dout. Go to IDLE.
- Arbitration (default): fixed priority; port 0 wins when both ports are pending.
- Read-after-write to the same address by back-to-back grants returns the new data, because the write commits before the next ACCESS.
- read_data = 0 whenever no read ack is asserted.
- Only one ack is high in any cycle.
- ram_addr holds its last value outside ACCESS/RDATA.
- ram_write is 0 outside ACCESS.

## Timing
- Reset values: state IDLE; ack0 = ack1 = 0; ram_write = 0; ram_addr = 0; ram_din = 0; read_data = 0; busy = 0; round-robin pointer set so that port 0 wins first.
- Reset during ACCESS or RDATA abandons the transaction: no ack is issued, and no write occurs in the reset cycle. The requester re-issues the command after reset.
- Latency, counted from the IDLE cycle in which the request is sampled (cycle N):
  - write: ack in N+1
  - read: ack in N+2
  - out-of-range access: ack in N+1
- The cycle after an ack is IDLE and re-samples both ports. A requester updates its cmd on the edge that ends its ack cycle, so back-to-back accesses need no extra dead cycle.
  - Sustained throughput: 1 write per 2 cycles; 1 read per 3 cycles.
- Port inputs are sampled only in IDLE. Changes to them during ACCESS or RDATA are ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant register updates in every IDLE→ACCESS transition.
  - When both ports are pending, the port that did not win last is granted.
  - After reset, port 0 wins first.
- MEM_ARB_RR_EN undefined: fixed priority, port 0 over port 1. No last-grant register exists.

## Structure
- Shared package mem_pkg holds:
  - the mem_cmd_t enum (MNONE, MWRITE, MREAD)
  - the arbiter state enum (IDLE, ACCESS, RDATA)
  - DATA_W and ADDR_W defaults
- Sub-module mem_arb_pick is combinational.
  - Inputs: two pending bits, plus the last-grant bit when MEM_ARB_RR_EN is defined.
  - Outputs: grant valid and winning port id.
- The RAM is outside this block.

## Test plan
- Port 0 MWRITE addr 0x005 data 0xABCD, then MREAD 0x005 → ram_write pulse in N+1; read ack0 two cycles after the read is sampled, with read_data = 0xABCD.
- Both ports issue MREAD in the same cycle (0x010 and 0x020, preloaded 0x1111 and 0x2222):
  - fixed priority: ack0 carries 0x1111, then ack1 carries 0x2222.
  - MEM_ARB_RR_EN, with both ports held pending: grants alternate 0, 1, 0, 1.
- Port 1 MREAD addr 0x105 → ack1 in N+1 with read_data = 0; ram_write stays 0. Port 1 MWRITE 0x1FF → ack1 in N+1; RAM contents unchanged.
- Port 0 streams 4 writes back-to-back → ack0 every 2 cycles; busy high exactly in the ACCESS cycles.
- Reset asserted in RDATA → no ack; all outputs at reset values the next cycle. The re-issued read completes normally.
- Port 0 cmd = 11 → treated as MNONE; the arbiter stays in IDLE and never asserts ack0.
